kpn_adder_node: RTL and testbench

Parametrised N-input Kahn-process-network adder node for the KPN software-program build. Each input channel has its own FIFO. The node fires only when every channel holds a token and the output slot can accept a result. Each firing pops one token per channel and emits the unsigned sum through a one-deep valid/rd output stage. It replaces the fixed two-FIFO plus adder chain that sits between the queue producers and the bcd/display path.

---
 rtl/kpn_adder_node.sv | 124 ++++++++++++
 tb/tb_kpn_adder_node.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/kpn_adder_node.sv
// N-input KPN adder node: per-channel FIFOs feed a one-deep valid/rd output stage.
// Optional build macro KPN_SATURATE_EN: clamp overflowing sums to all ones instead of wrapping.
module kpn_adder_node #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       wr,
  input  logic [N_CH*WIDTH-1:0] entry,
  output logic [N_CH-1:0]       full,
  input  logic                  rd,
  output logic [WIDTH-1:0]      output_1,
  output logic                  valid,
  output logic [CNT_W-1:0]      fire_count,
  output logic                  overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SumW = WIDTH + $clog2(N_CH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic              ovf_q, ovf_d;

  logic [N_CH-1:0]   nonempty;
  logic [WIDTH-1:0]  head [N_CH];
  logic              can_accept;
  logic              fire;
  logic [SumW-1:0]   sum_full;
  logic              sum_ovf;
  logic [WIDTH-1:0]  sum_out;

  assign valid      = (state_q == StHold);
  assign can_accept = !valid || rd;
  assign fire       = (&nonempty) && can_accept;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             push;

    // Full is sampled before any same-cycle pop, so a write to a full FIFO is always dropped.
    assign push        = wr[g] && (cnt_q != FullCnt);
    assign full[g]     = (cnt_q == FullCnt);
    assign nonempty[g] = (cnt_q != '0);
    assign head[g]     = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (fire) rptr_q <= rptr_q + 1'b1;
        if (push && !fire)      cnt_q <= cnt_q + 1'b1;
        else if (!push && fire) cnt_q <= cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= entry[g*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    sum_full = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_full = sum_full + SumW'(head[i]);
    end
  end

  assign sum_ovf = |sum_full[SumW-1:WIDTH];

`ifdef KPN_SATURATE_EN
  assign sum_out = sum_ovf ? '1 : sum_full[WIDTH-1:0];
`else
  assign sum_out = sum_full[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    fc_d    = fc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: if (fire) state_d = StHold;
      StHold: if (rd && !fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (fire) begin
      out_d = sum_out;
      fc_d  = fc_q + 1'b1;
      if (sum_ovf) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= '0;
      fc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fc_q    <= fc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign output_1   = out_q;
  assign fire_count = fc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_kpn_adder_node.sv
// Self-checking bench for kpn_adder_node (N_CH=2, WIDTH=16, DEPTH=4): vector table plus
// hand-written reset, overflow and streaming sequences.
module tb_kpn_adder_node;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr;
  logic [31:0] entry;
  logic [1:0]  full;
  logic        rd;
  logic [15:0] output_1;
  logic        valid;
  logic [15:0] fire_count;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  kpn_adder_node #(
    .N_CH (2),
    .WIDTH(16),
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .entry     (entry),
    .full      (full),
    .rd        (rd),
    .output_1  (output_1),
    .valid     (valid),
    .fire_count(fire_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wr;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        rd;
    logic        x_valid;
    logic [15:0] x_out;
    logic [1:0]  x_full;
    logic [15:0] x_fc;
    logic        x_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] w, input logic [15:0] a, input logic [15:0] b,
                     input logic r, input logic xv, input logic [15:0] xo,
                     input logic [1:0] xf, input logic [15:0] xc, input logic xov);
    vec_t v;
    v.wr = w; v.e0 = a; v.e1 = b; v.rd = r;
    v.x_valid = xv; v.x_out = xo; v.x_full = xf; v.x_fc = xc; v.x_ovf = xov;
    vq.push_back(v);
  endtask

  logic [15:0] ovf_exp;

  initial begin
`ifdef KPN_SATURATE_EN
    ovf_exp = 16'hFFFF;
`else
    ovf_exp = 16'h0001;
`endif
    // Single firing, then consume.
    add(2'b11, 16'd5, 16'd7, 1'b0, 1'b0, 16'd0,  2'b00, 16'd0, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b0, 1'b1, 16'd12, 2'b00, 16'd1, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b0, 16'd12, 2'b00, 16'd1, 1'b0);
    // Backpressure: first firing holds, FIFOs fill, an extra write is dropped.
    add(2'b11, 16'd1,  16'd10, 1'b0, 1'b0, 16'd12, 2'b00, 16'd1, 1'b0);
    add(2'b11, 16'd2,  16'd11, 1'b0, 1'b1, 16'd11, 2'b00, 16'd2, 1'b0);
    add(2'b11, 16'd3,  16'd12, 1'b0, 1'b1, 16'd11, 2'b00, 16'd2, 1'b0);
    add(2'b11, 16'd4,  16'd13, 1'b0, 1'b1, 16'd11, 2'b00, 16'd2, 1'b0);
    add(2'b11, 16'd5,  16'd14, 1'b0, 1'b1, 16'd11, 2'b11, 16'd2, 1'b0);
    add(2'b11, 16'd99, 16'd99, 1'b0, 1'b1, 16'd11, 2'b11, 16'd2, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b1, 16'd13, 2'b00, 16'd3, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b1, 16'd15, 2'b00, 16'd4, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b1, 16'd17, 2'b00, 16'd5, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b1, 16'd19, 2'b00, 16'd6, 1'b0);
    add(2'b00, 16'd0, 16'd0, 1'b1, 1'b0, 16'd19, 2'b00, 16'd6, 1'b0);
    // Unbalanced channels.
    add(2'b01, 16'd30, 16'd0,   1'b0, 1'b0, 16'd19,  2'b00, 16'd6, 1'b0);
    add(2'b01, 16'd31, 16'd0,   1'b0, 1'b0, 16'd19,  2'b00, 16'd6, 1'b0);
    add(2'b01, 16'd32, 16'd0,   1'b0, 1'b0, 16'd19,  2'b00, 16'd6, 1'b0);
    add(2'b10, 16'd0,  16'd100, 1'b0, 1'b0, 16'd19,  2'b00, 16'd6, 1'b0);
    add(2'b00, 16'd0,  16'd0,   1'b0, 1'b1, 16'd130, 2'b00, 16'd7, 1'b0);
    add(2'b00, 16'd0,  16'd0,   1'b0, 1'b1, 16'd130, 2'b00, 16'd7, 1'b0);
    add(2'b00, 16'd0,  16'd0,   1'b1, 1'b0, 16'd130, 2'b00, 16'd7, 1'b0);

    rst_n = 1'b0; wr = '0; entry = '0; rd = 1'b0;
    #12;
    check("reset valid", 32'(valid), 32'd0);
    check("reset output_1", 32'(output_1), 32'd0);
    check("reset fire_count", 32'(fire_count), 32'd0);
    check("reset full", 32'(full), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      wr = vq[k].wr; entry = {vq[k].e1, vq[k].e0}; rd = vq[k].rd;
      tick();
      check($sformatf("v%0d valid", k), 32'(valid), 32'(vq[k].x_valid));
      check($sformatf("v%0d output_1", k), 32'(output_1), 32'(vq[k].x_out));
      check($sformatf("v%0d full", k), 32'(full), 32'(vq[k].x_full));
      check($sformatf("v%0d fire_count", k), 32'(fire_count), 32'(vq[k].x_fc));
      check($sformatf("v%0d overflow", k), 32'(overflow), 32'(vq[k].x_ovf));
    end

    // Asynchronous reset while holding a token with partly filled FIFOs.
    wr = 2'b10; entry = {16'd1, 16'd0}; rd = 1'b0;
    tick();
    wr = 2'b00;
    tick();
    check("pre-reset fire", 32'(output_1), 32'd32);
    wr = 2'b11; entry = {16'd8, 16'd7};
    tick();
    tick();
    wr = 2'b00;
    check("pre-reset hold valid", 32'(valid), 32'd1);
    check("pre-reset hold output_1", 32'(output_1), 32'd32);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", 32'(valid), 32'd0);
    check("async reset output_1", 32'(output_1), 32'd0);
    check("async reset fire_count", 32'(fire_count), 32'd0);
    check("async reset full", 32'(full), 32'd0);
    check("async reset overflow", 32'(overflow), 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post-reset idle valid %0d", k), 32'(valid), 32'd0);
      check($sformatf("post-reset idle fire_count %0d", k), 32'(fire_count), 32'd0);
    end

    // Largest sum that fits, then a wrapping/saturating one.
    wr = 2'b11; entry = {16'h0001, 16'hFFFE};
    tick();
    wr = 2'b00;
    tick();
    check("max sum output_1", 32'(output_1), 32'h0000FFFF);
    check("max sum overflow", 32'(overflow), 32'd0);
    wr = 2'b11; entry = {16'h0002, 16'hFFFF}; rd = 1'b1;
    tick();
    check("consume max sum valid", 32'(valid), 32'd0);
    wr = 2'b00; rd = 1'b0;
    tick();
    check("ovf valid", 32'(valid), 32'd1);
    check("ovf output_1", 32'(output_1), 32'(ovf_exp));
    check("ovf overflow", 32'(overflow), 32'd1);
    check("ovf fire_count", 32'(fire_count), 32'd2);
    rd = 1'b1;
    tick();
    check("ovf consumed valid", 32'(valid), 32'd0);
    check("ovf sticky", 32'(overflow), 32'd1);

    // Streaming at one token per cycle.
    for (int i = 1; i <= 10; i++) begin
      wr = 2'b11; entry = {16'(2 * i), 16'(i)};
      tick();
      check($sformatf("stream %0d full", i), 32'(full), 32'd0);
      if (i == 1) begin
        check("stream first valid", 32'(valid), 32'd0);
      end else begin
        check($sformatf("stream %0d valid", i), 32'(valid), 32'd1);
        check($sformatf("stream %0d output_1", i), 32'(output_1), 32'(3 * (i - 1)));
        check($sformatf("stream %0d fire_count", i), 32'(fire_count), 32'(i + 1));
      end
    end
    wr = 2'b00;
    tick();
    check("stream tail output_1", 32'(output_1), 32'd30);
    check("stream tail fire_count", 32'(fire_count), 32'd12);
    check("stream tail valid", 32'(valid), 32'd1);
    tick();
    check("stream drained valid", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
